// File: rtl/bus_timer.sv
// Memory-mapped countdown timer (CTRL / PRESET / COUNT) with one-shot and auto-reload modes.
// Optional build macro TIMER_BYTEEN_EN: register writes honour the byteen byte enables.
module bus_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state, next_state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        en, auto_reload;
  logic        wr, ctrl_wr, preset_wr;
  logic [31:0] byte_mask;
  logic        load_count, dec_count, set_flag, reload_clear, oneshot_stop;

  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign wr          = sel && we;

`ifdef TIMER_BYTEEN_EN
  assign byte_mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign ctrl_wr   = wr && (addr == 2'd0) && byteen[0];
  assign preset_wr = wr && (addr == 2'd1) && (byteen != 4'b0000);
`else
  // Byte enables have no effect in this build; the OR keeps the mask at all-ones.
  assign byte_mask = 32'hFFFF_FFFF |
                     {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign ctrl_wr   = wr && (addr == 2'd0);
  assign preset_wr = wr && (addr == 2'd1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (en) next_state = S_LOAD;
      S_LOAD: next_state = en ? S_CNT : S_IDLE;
      S_CNT: begin
        if (!en)              next_state = S_IDLE;
        else if (count == 0)  next_state = S_INT;
      end
      S_INT:  next_state = (auto_reload && en) ? S_LOAD : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    load_count   = (state == S_LOAD);
    dec_count    = (state == S_CNT) && en && (count != 32'd0);
    set_flag     = (state == S_CNT) && en && (count == 32'd0);
    reload_clear = (state == S_INT) && auto_reload;
    oneshot_stop = (state == S_INT) && !auto_reload;
  end

  // A CPU write to CTRL overrides any same-edge FSM update of EN or irq_flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= 4'd0;
      irq_flag <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl     <= wdata[3:0];
      irq_flag <= 1'b0;
    end else begin
      if (oneshot_stop) ctrl[0] <= 1'b0;
      if (set_flag)          irq_flag <= 1'b1;
      else if (reload_clear) irq_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          preset <= 32'd0;
    else if (preset_wr) preset <= (preset & ~byte_mask) | (wdata & byte_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count <= 32'd0;
    else if (load_count) count <= preset;
    else if (dec_count)  count <= count - 32'd1;
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata = {28'd0, ctrl};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = ctrl[3] & irq_flag;

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown timer: a bus responder serving the pipeline CPU's data-side load/store accesses.
- Sits behind the system bridge. The bridge decodes the CPU address and drives sel, addr, we, wdata and byteen.
- The timer returns rdata combinationally and raises irq toward the CPU's interrupt logic.

Parameters:
- (none)

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- sel  input  1  chip select from bridge; writes are ignored when 0.
- addr  input  2  word offset (CPU address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  write strobe; write occurs at clk edge when sel&&we.
- wdata  input  32  write data.
- byteen  input  4  byte enables; used only with TIMER_BYTEEN_EN.
- rdata  output  32  combinational read data for addr.
- irq  output  1  interrupt request = CTRL.IM & irq_flag.

Behaviour:
- CTRL register: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM. Bits [31:4] not stored; read as 0.
- PRESET: 32-bit read/write.
- COUNT: read-only; writes ignored.
- addr 3: reads 0, writes ignored.
- rdata: addr0 -> {28'b0,CTRL}, addr1 -> PRESET, addr2 -> COUNT, addr3 -> 0. Purely combinational, independent of sel.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Hence irq=0 and rdata=0.
- Any CTRL write clears irq_flag at the same edge.
- A PRESET write does not affect a running COUNT; it takes effect at the next LOAD.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN -> LOAD; COUNT holds.
  - LOAD: COUNT<=PRESET; if EN -> CNT, else -> IDLE.
  - CNT: if !EN -> IDLE (COUNT frozen). Else if COUNT==0 -> INT and irq_flag<=1. Else COUNT<=COUNT-1.
  - INT, MODE 00: EN<=0, -> IDLE; irq_flag holds until a CTRL write.
  - INT, MODE 01: irq_flag<=0, -> LOAD (if EN) or IDLE.
- Latency: with PRESET=P, a CTRL write setting EN at edge E0 gives state=INT and irq_flag=1 after edge E0+P+3.
  - Auto-reload period is P+3 cycles.
  - The irq pulse is exactly 1 cycle wide in MODE 01.
- PRESET=0: LOAD->CNT->INT, so irq after 3 edges. COUNT never wraps below 0.
- Simultaneous CPU CTRL write and FSM update of EN/irq_flag at the same edge: the CPU write wins. CTRL takes wdata and irq_flag=0; the FSM state transition still happens.
- EN cleared during LOAD/CNT: next state IDLE; COUNT retains its value.
- Reset asserted mid-count: all state clears asynchronously; counting resumes only after a new EN write.

Optional Feature:
- Macro: TIMER_BYTEEN_EN.
- Defined: a write updates only bytes i where byteen[i]=1.
  - CTRL updates only if byteen[0]=1; that write clears irq_flag, and otherwise no irq_flag clear.
  - byteen=0 makes the write a no-op.
- Undefined: byteen is ignored; sel&&we writes the full word.

Test Plan:
1. Reset, then read addr0/1/2/3 -> rdata=0 each; irq=0. Assert reset mid-count with COUNT=7 -> COUNT=0, irq=0, state IDLE immediately (no clock edge needed).
2. PRESET=5, CTRL=0x9 (IM=1, EN=1, one-shot) -> irq rises 8 edges after the CTRL write and stays high. Then: CTRL.EN reads 0; COUNT reads 0; writing CTRL=0x8 drops irq next cycle.
3. PRESET=3, CTRL=0xB (auto-reload) -> 1-cycle irq pulses every 6 cycles; at least 3 periods checked. Writing PRESET=10 mid-count -> the next period becomes 13 only after the following LOAD.
4. PRESET=100, start; after 20 cycles write CTRL=0x8 -> COUNT frozen at the read value, no irq. Write COUNT=0x55 -> COUNT unchanged.
5. PRESET=0, CTRL=0x1 (IM=0) -> irq stays 0; internal flag set (verified by setting IM=1 without CTRL write... not possible, so check CTRL write clears flag). Also: a CTRL write on the same edge as the INT transition -> CTRL equals wdata and irq=0.
6. With TIMER_BYTEEN_EN: PRESET=0, write 0xAABBCCDD with byteen=0101 -> PRESET=0x00BB00DD; byteen=0000 -> unchanged. Without the macro: same write -> 0xAABBCCDD.
